// File: rtl/mic1_ctrl_pkg.sv
// Shared types and defaults for the MIC-1 execution controller.
//   exec_state_t : controller state encoding, also exported on state_o
//   MPC_W_DEF    : default micro-program counter / breakpoint width
//   CNT_W_DEF    : default executed-microcycle counter width
package mic1_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    PAUSE = 3'd3,
    HALT  = 3'd4
  } exec_state_t;

  localparam int unsigned MPC_W_DEF = 9;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/mic1_exec_ctrl_if.sv
// Bundle of signals between the front panel / MIC-1 core and the execution controller.
//   Commands : cmd_run, cmd_stop, cmd_step, cmd_sreset (debounced, clk-synchronous levels)
//   Core     : mic1_halt, mpc in; mic1_clk_en, mic1_sreset out
//   Debug    : bp_en, bp_addr in; bp_hit out
//   Status   : state_o, led_idle/run/pause/halt, cycle_cnt, led_run_step out
// Modports:
//   slave  - the controller (receives commands, drives enables and status)
//   master - the surrounding board / core / testbench
interface mic1_exec_ctrl_if import mic1_ctrl_pkg::*; #(
  parameter int unsigned MPC_W = MPC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
);

  logic             cmd_run;
  logic             cmd_stop;
  logic             cmd_step;
  logic             cmd_sreset;
  logic             mic1_halt;
  logic [MPC_W-1:0] mpc;
  logic             bp_en;
  logic [MPC_W-1:0] bp_addr;

  logic             mic1_clk_en;
  logic             mic1_sreset;
  logic [2:0]       state_o;
  logic             led_idle;
  logic             led_run;
  logic             led_pause;
  logic             led_halt;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [3:0]       led_run_step;

  modport slave (
    input  cmd_run, cmd_stop, cmd_step, cmd_sreset,
    input  mic1_halt, mpc, bp_en, bp_addr,
    output mic1_clk_en, mic1_sreset, state_o,
    output led_idle, led_run, led_pause, led_halt,
    output bp_hit, cycle_cnt, led_run_step
  );

  modport master (
    output cmd_run, cmd_stop, cmd_step, cmd_sreset,
    output mic1_halt, mpc, bp_en, bp_addr,
    input  mic1_clk_en, mic1_sreset, state_o,
    input  led_idle, led_run, led_pause, led_halt,
    input  bp_hit, cycle_cnt, led_run_step
  );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector for one clk-synchronous level.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   level : input level
//   pulse : high during the first cycle that level is high
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Combinational so a command rising before edge k is acted on at edge k.
  assign pulse = level & ~level_q;

endmodule

// File: rtl/mic1_exec_ctrl.sv
// Execution controller for the MIC-1 datapath.
// Turns front-panel commands into a per-cycle core enable, stops on breakpoint or HALT,
// counts executed microcycles (saturating) and drives the status LEDs.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : mic1_exec_ctrl_if.slave (commands, core status, enables, LEDs, counter)
module mic1_exec_ctrl import mic1_ctrl_pkg::*; #(
  parameter int unsigned MPC_W = MPC_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic              clk,
  input logic              reset,
  mic1_exec_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Command edge pulses
  logic run_p;
  logic stop_p;
  logic step_p;
  logic sreset_p;

  edge_detect u_ed_run (
    .clk   (clk),
    .reset (reset),
    .level (bus.cmd_run),
    .pulse (run_p)
  );

  edge_detect u_ed_stop (
    .clk   (clk),
    .reset (reset),
    .level (bus.cmd_stop),
    .pulse (stop_p)
  );

  edge_detect u_ed_step (
    .clk   (clk),
    .reset (reset),
    .level (bus.cmd_step),
    .pulse (step_p)
  );

  edge_detect u_ed_sreset (
    .clk   (clk),
    .reset (reset),
    .level (bus.cmd_sreset),
    .pulse (sreset_p)
  );

  // State
  exec_state_t      state_q, state_d;
  logic             resume_skip_q, resume_skip_d;
  logic             bp_hit_q, bp_hit_d;
  logic             sreset_q, sreset_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [MPC_W-1:0] mpc;
  logic [MPC_W-1:0] bp_addr;
  logic             bp_stop;
  logic             clk_en;

  assign mpc     = bus.mpc;
  assign bp_addr = bus.bp_addr;

  // resume_skip masks the breakpoint for the first RUN cycle after a resume,
  // so the core can step off the address it stopped on.
  assign bp_stop = bus.bp_en && (mpc == bp_addr) && !resume_skip_q;

  // Zero-latency gating: a breakpoint or HALT microinstruction never executes in RUN.
  always_comb begin
    clk_en = 1'b0;
    unique case (state_q)
      RUN:     clk_en = !bp_stop && !bus.mic1_halt;
      STEP:    clk_en = !bus.mic1_halt;
      default: clk_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    resume_skip_d = resume_skip_q;
    bp_hit_d      = bp_hit_q;
    sreset_d      = 1'b0;
    cnt_d         = cnt_q;

    if (clk_en && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (sreset_p) begin
      // Soft reset overrides everything, including this cycle's count.
      state_d       = IDLE;
      resume_skip_d = 1'b0;
      bp_hit_d      = 1'b0;
      cnt_d         = '0;
      sreset_d      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (step_p) begin
            state_d = STEP;
          end else if (run_p) begin
            state_d = RUN;
          end
        end
        RUN: begin
          resume_skip_d = 1'b0;
          if (bus.mic1_halt) begin
            state_d = HALT;
          end else if (bp_stop) begin
            state_d  = PAUSE;
            bp_hit_d = 1'b1;
          end else if (stop_p) begin
            state_d = PAUSE;
          end
        end
        STEP: begin
          state_d = bus.mic1_halt ? HALT : PAUSE;
        end
        PAUSE: begin
          // A stop edge outranks run/step and simply keeps us paused.
          if (!stop_p) begin
            if (step_p) begin
              state_d  = STEP;
              bp_hit_d = 1'b0;
            end else if (run_p) begin
              state_d       = RUN;
              resume_skip_d = 1'b1;
              bp_hit_d      = 1'b0;
            end
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      resume_skip_q <= 1'b0;
      bp_hit_q      <= 1'b0;
      sreset_q      <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      resume_skip_q <= resume_skip_d;
      bp_hit_q      <= bp_hit_d;
      sreset_q      <= sreset_d;
      cnt_q         <= cnt_d;
    end
  end

  // Outputs, all decoded from registered state (glitch-free LEDs)
  assign bus.mic1_clk_en  = clk_en;
  assign bus.mic1_sreset  = sreset_q;
  assign bus.state_o      = state_q;
  assign bus.led_idle     = (state_q == IDLE);
  assign bus.led_run      = (state_q == RUN) || (state_q == STEP);
  assign bus.led_pause    = (state_q == PAUSE);
  assign bus.led_halt     = (state_q == HALT);
  assign bus.bp_hit       = bp_hit_q;
  assign bus.cycle_cnt    = cnt_q;
  assign bus.led_run_step = cnt_q[3:0];

endmodule

// File: tb/tb_mic1_exec_ctrl.sv
// Self-checking bench for mic1_exec_ctrl: expected snapshots are queued as stimulus is
// driven, observed snapshots are captured each cycle, and each scenario compares them.
module tb_mic1_exec_ctrl;

  localparam logic [2:0] SI = 3'd0;
  localparam logic [2:0] SR = 3'd1;
  localparam logic [2:0] SS = 3'd2;
  localparam logic [2:0] SP = 3'd3;
  localparam logic [2:0] SH = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mic1_exec_ctrl_if #(.MPC_W(9), .CNT_W(16)) bus ();
  mic1_exec_ctrl_if #(.MPC_W(9), .CNT_W(4))  bus4 ();

  mic1_exec_ctrl #(.MPC_W(9), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mic1_exec_ctrl #(.MPC_W(9), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        en;
    logic        sr;
    logic        bp;
    logic [3:0]  leds;  // {idle, run, pause, halt}
    logic [15:0] cnt;
  } snap_t;

  int    tests = 0;
  int    fails = 0;
  bit    trk   = 1'b0;  // advance mpc like a core would on enabled cycles
  snap_t exp_q[$];
  snap_t obs_q[$];
  string name_q[$];

  function automatic snap_t mk(input logic [2:0] st, input logic en, input logic sr,
                               input logic bp, input logic [15:0] cnt);
    snap_t s;
    s.st = st; s.en = en; s.sr = sr; s.bp = bp; s.cnt = cnt;
    case (st)
      SI:      s.leds = 4'b1000;
      SR, SS:  s.leds = 4'b0100;
      SP:      s.leds = 4'b0010;
      default: s.leds = 4'b0001;
    endcase
    return s;
  endfunction

  function automatic snap_t obs();
    snap_t s;
    s.st   = bus.state_o;
    s.en   = bus.mic1_clk_en;
    s.sr   = bus.mic1_sreset;
    s.bp   = bus.bp_hit;
    s.leds = {bus.led_idle, bus.led_run, bus.led_pause, bus.led_halt};
    s.cnt  = bus.cycle_cnt;
    return s;
  endfunction

  // Drive one cycle of command levels, queue the expectation, sample at negedge.
  task automatic cyc(input logic run, input logic stop, input logic step, input logic sr,
                     input snap_t e, input string nm);
    logic en_s;
    bus.cmd_run = run; bus.cmd_stop = stop; bus.cmd_step = step; bus.cmd_sreset = sr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    obs_q.push_back(obs());
    en_s = bus.mic1_clk_en;
    @(posedge clk);
    #1;
    if (en_s && trk) bus.mpc = bus.mpc + 9'd1;
  endtask

  task automatic test_reset();
    snap_t e, o;
    string nm;
    cyc(0, 0, 0, 0, mk(SI, 0, 0, 0, 0), "reset_idle0");
    cyc(0, 0, 0, 0, mk(SI, 0, 0, 0, 0), "reset_idle1");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_step();
    snap_t e, o;
    string nm;
    int    n_en;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, mk(i == 0 ? SI : SP, 0, 0, 0, 16'(i)), $sformatf("step%0d_cmd", i));
      cyc(0, 0, 0, 0, mk(SS, 1, 0, 0, 16'(i)), $sformatf("step%0d_exec", i));
      cyc(0, 0, 0, 0, mk(SP, 0, 0, 0, 16'(i + 1)), $sformatf("step%0d_pause", i));
    end
    n_en = 0;
    foreach (obs_q[i]) if (obs_q[i].en === 1'b1) n_en++;
    tests++;
    if (n_en != 3) begin fails++; $display("FAIL step_en_count: got %0d want 3", n_en); end
    tests++;
    if (bus.led_run_step !== 4'h3) begin
      fails++; $display("FAIL step_led_run_step: got %h want 3", bus.led_run_step);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_breakpoint();
    snap_t e, o;
    string nm;
    cyc(0, 0, 0, 1, mk(SP, 0, 0, 0, 3), "bp_sr_cmd");
    cyc(0, 0, 0, 0, mk(SI, 0, 1, 0, 0), "bp_sr_pulse");
    bus.bp_en = 1'b1; bus.bp_addr = 9'h020; bus.mpc = 9'h016; trk = 1'b1;
    cyc(1, 0, 0, 0, mk(SI, 0, 0, 0, 0), "bp_run_cmd");
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 16'(k)), $sformatf("bp_run%0d", k));
    end
    cyc(0, 0, 0, 0, mk(SR, 0, 0, 0, 10), "bp_gate");
    cyc(0, 0, 0, 0, mk(SP, 0, 0, 1, 10), "bp_paused");
    cyc(1, 0, 0, 0, mk(SP, 0, 0, 1, 10), "bp_resume_cmd");
    cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 10), "bp_resume_at_bp");
    cyc(0, 1, 0, 0, mk(SR, 1, 0, 0, 11), "bp_run_on");
    cyc(0, 0, 0, 0, mk(SP, 0, 0, 0, 12), "bp_stopped");
    trk = 1'b0; bus.bp_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_halt();
    snap_t e, o;
    string nm;
    cyc(0, 0, 0, 1, mk(SP, 0, 0, 0, 12), "h_sr_cmd0");
    cyc(0, 0, 0, 0, mk(SI, 0, 1, 0, 0), "h_sr_pulse0");
    cyc(1, 0, 0, 0, mk(SI, 0, 0, 0, 0), "h_run_cmd");
    cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 0), "h_run0");
    cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 1), "h_run1");
    bus.mic1_halt = 1'b1;
    cyc(0, 0, 0, 0, mk(SR, 0, 0, 0, 2), "h_gate");
    cyc(0, 0, 0, 0, mk(SH, 0, 0, 0, 2), "h_halted");
    cyc(1, 0, 0, 0, mk(SH, 0, 0, 0, 2), "h_run_ignored");
    cyc(0, 0, 1, 0, mk(SH, 0, 0, 0, 2), "h_step_ignored");
    cyc(0, 0, 0, 0, mk(SH, 0, 0, 0, 2), "h_hold");
    cyc(0, 0, 0, 1, mk(SH, 0, 0, 0, 2), "h_sr_cmd");
    cyc(0, 0, 0, 0, mk(SI, 0, 1, 0, 0), "h_sr_pulse");
    bus.mic1_halt = 1'b0;
    cyc(0, 0, 0, 0, mk(SI, 0, 0, 0, 0), "h_sr_one_cycle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_stop_run_same();
    snap_t e, o;
    string nm;
    cyc(0, 0, 1, 0, mk(SI, 0, 0, 0, 0), "sr_step_cmd");
    cyc(0, 0, 0, 0, mk(SS, 1, 0, 0, 0), "sr_step_exec");
    cyc(0, 0, 0, 0, mk(SP, 0, 0, 0, 1), "sr_paused");
    cyc(1, 1, 0, 0, mk(SP, 0, 0, 0, 1), "sr_both_cmd");
    cyc(0, 0, 0, 0, mk(SP, 0, 0, 0, 1), "sr_still_paused0");
    cyc(0, 0, 0, 0, mk(SP, 0, 0, 0, 1), "sr_still_paused1");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_sreset_run();
    snap_t e, o;
    string nm;
    cyc(1, 0, 0, 1, mk(SP, 0, 0, 0, 1), "srr_cmd");
    cyc(0, 0, 0, 0, mk(SI, 0, 1, 0, 0), "srr_idle_pulse");
    cyc(0, 0, 0, 0, mk(SI, 0, 0, 0, 0), "srr_idle");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    string nm;
    cyc(1, 0, 0, 0, mk(SI, 0, 0, 0, 0), "ar_run_cmd");
    cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 0), "ar_run0");
    cyc(0, 0, 0, 0, mk(SR, 1, 0, 0, 1), "ar_run1");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
      tests++;
      if (o !== e) begin fails++; $display("FAIL %s: got %h want %h", nm, o, e); end
    end
    #2;
    tests++;
    if (bus.mic1_clk_en !== 1'b1) begin
      fails++; $display("FAIL ar_pre_en: got %b want 1", bus.mic1_clk_en);
    end
    reset = 1'b1;
    #1;
    o = obs();
    e = mk(SI, 0, 0, 0, 0);
    tests++;
    if (o !== e) begin fails++; $display("FAIL ar_immediate: got %h want %h", o, e); end
    #4;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    logic [3:0] want;
    bus4.cmd_run = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    bus4.cmd_run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      want = (k < 15) ? 4'(k) : 4'hF;
      @(negedge clk);
      tests++;
      if (bus4.cycle_cnt !== want || bus4.mic1_clk_en !== 1'b1) begin
        fails++;
        $display("FAIL sat%0d: got cnt=%h en=%b want cnt=%h en=1", k, bus4.cycle_cnt,
                 bus4.mic1_clk_en, want);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    tests++;
    if (bus4.cycle_cnt !== 4'hF) begin
      fails++; $display("FAIL sat_final: got %h want f", bus4.cycle_cnt);
    end
  endtask

  initial begin
    bus.cmd_run = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_step = 1'b0; bus.cmd_sreset = 1'b0;
    bus.mic1_halt = 1'b0; bus.mpc = '0; bus.bp_en = 1'b0; bus.bp_addr = '0;
    bus4.cmd_run = 1'b0; bus4.cmd_stop = 1'b0; bus4.cmd_step = 1'b0; bus4.cmd_sreset = 1'b0;
    bus4.mic1_halt = 1'b0; bus4.mpc = '0; bus4.bp_en = 1'b0; bus4.bp_addr = '0;
    #12;
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_step();
    test_breakpoint();
    test_halt();
    test_stop_run_same();
    test_sreset_run();
    test_async_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
